arbiter_rr_lock: RTL and testbench

//  Parametrised N-requester arbiter; registered successor to the 4-bit combinational daisy-chain arbiter.

---
 rtl/arbiter_rr_lock_if.sv | 21 ++
 rtl/arbiter_rr_lock.sv | 95 +++++++++
 tb/tb_arbiter_rr_lock.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/arbiter_rr_lock_if.sv
// rtl/arbiter_rr_lock_if.sv - request/grant bundle between N bus masters and the arbiter
interface arbiter_rr_lock_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
);
    logic [0:N-1]     req;
    logic [0:N-1]     gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             preempt;

    modport master (
        output req,
        input  gnt, gnt_valid, gnt_idx, preempt
    );

    modport slave (
        input  req,
        output gnt, gnt_valid, gnt_idx, preempt
    );
endinterface

// File: rtl/arbiter_rr_lock.sv
// rtl/arbiter_rr_lock.sv - registered N-way fixed/round-robin arbiter with grant lock and hold limit
module arbiter_rr_lock #(
    parameter int N        = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    arbiter_rr_lock_if.slave bus
);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [0:N-1]      gnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;
    logic              pre_q;

    logic [0:N-1]      cand;
    logic [0:N-1]      win_oh;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  pos;
    logic [IDX_W-1:0]  ptr_nxt;
    logic              own_req;
    logic              others;
    logic              expire;

    // The current owner never competes in its own successor selection.
    always_comb begin
        cand = bus.req;
        if (state == OWNED) cand[idx_q] = 1'b0;
        own_req = (state == OWNED) && bus.req[idx_q];
        others  = |cand;
        win     = '0;
        pos     = '0;
        if (RR_MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                pos = IDX_W'(i);
                if (cand[pos]) win = pos;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                pos = IDX_W'((int'(ptr) + k) % N);
                if (cand[pos]) win = pos;
            end
        end
        win_oh      = '0;
        win_oh[win] = 1'b1;
        ptr_nxt     = (win == IDX_W'(N - 1)) ? '0 : win + 1'b1;
        // Saturated counters still expire, so a long-running owner yields once someone arrives.
        expire = (MAX_HOLD > 0) && own_req && others &&
                 (hold_cnt >= HOLD_W'(MAX_HOLD - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            pre_q    <= 1'b0;
        end else begin
            pre_q <= 1'b0;
            if (own_req && !expire) begin
                if ((MAX_HOLD > 0) && (hold_cnt < HOLD_W'(MAX_HOLD)))
                    hold_cnt <= hold_cnt + 1'b1;
            end else if (others) begin
                state    <= OWNED;
                gnt_q    <= win_oh;
                idx_q    <= win;
                valid_q  <= 1'b1;
                hold_cnt <= '0;
                ptr      <= ptr_nxt;
                pre_q    <= expire;
            end else begin
                state    <= IDLE;
                gnt_q    <= '0;
                valid_q  <= 1'b0;
                hold_cnt <= '0;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.preempt   = pre_q;
endmodule

// File: tb/tb_arbiter_rr_lock.sv
// tb/tb_arbiter_rr_lock.sv - directed scoreboard bench for fixed, round-robin and hold-limited arbiters
module tb_arbiter_rr_lock;
    logic clk;
    logic rst_n;

    arbiter_rr_lock_if #(.N(4)) bf ();
    arbiter_rr_lock_if #(.N(4)) br ();
    arbiter_rr_lock_if #(.N(4)) bh ();

    arbiter_rr_lock #(.N(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(bf));
    arbiter_rr_lock #(.N(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(br));
    arbiter_rr_lock #(.N(4), .RR_MODE(1), .MAX_HOLD(4)) u_hld (.clk(clk), .rst_n(rst_n), .bus(bh));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        string      tag;
        logic [0:3] gnt;
        logic [1:0] idx;
        logic       pre;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [0:3] oh(int i);
        logic [0:3] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic push(int d, string t, logic [0:3] g, logic [1:0] i, logic p);
        exp_t e;
        e.dut = d; e.tag = t; e.gnt = g; e.idx = i; e.pre = p;
        sb.push_back(e);
    endtask

    task automatic cmp(string t, string f, logic [7:0] o, logic [7:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s.%s: observed %0h expected %0h", t, f, o, e);
        end
    endtask

    task automatic cycle();
        exp_t       e;
        logic [0:3] g;
        logic       v;
        logic [1:0] i;
        logic       p;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin g = bf.gnt; v = bf.gnt_valid; i = bf.gnt_idx; p = bf.preempt; end
                1:       begin g = br.gnt; v = br.gnt_valid; i = br.gnt_idx; p = br.preempt; end
                default: begin g = bh.gnt; v = bh.gnt_valid; i = bh.gnt_idx; p = bh.preempt; end
            endcase
            cmp(e.tag, "gnt",       {4'b0, g},    {4'b0, e.gnt});
            cmp(e.tag, "gnt_valid", {7'b0, v},    {7'b0, |e.gnt});
            cmp(e.tag, "gnt_idx",   {6'b0, i},    {6'b0, e.idx});
            cmp(e.tag, "preempt",   {7'b0, p},    {7'b0, e.pre});
        end
    endtask

    initial begin
        logic [0:3] r;
        logic [0:3] g;
        logic [1:0] ix;
        logic [1:0] last;

        rst_n  = 1'b0;
        bf.req = 4'b1111;
        br.req = 4'b1111;
        bh.req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 3; d++) push(d, "reset", 4'b0000, 2'd0, 1'b0);
            cycle();
        end
        rst_n  = 1'b1;
        bf.req = 4'b0000;
        br.req = 4'b0000;
        bh.req = 4'b0000;
        for (int d = 0; d < 3; d++) push(d, "idle", 4'b0000, 2'd0, 1'b0);
        cycle();

        // Fixed priority sweep: lowest index wins, grant drops with the request.
        last = 2'd0;
        for (int v = 0; v < 16; v++) begin
            r  = 4'(v);
            g  = '0;
            ix = last;
            for (int b = 3; b >= 0; b--)
                if (r[b]) begin g = oh(b); ix = 2'(b); end
            bf.req = r;
            for (int c = 0; c < 3; c++) begin
                push(0, "fixed", g, ix, 1'b0);
                cycle();
            end
            last   = ix;
            bf.req = 4'b0000;
            push(0, "fixed_rel", 4'b0000, last, 1'b0);
            cycle();
        end

        // Round-robin rotation with back-to-back hand-over.
        br.req = 4'b1111;
        push(1, "rr", oh(0), 2'd0, 1'b0);
        cycle();
        for (int k = 0; k < 4; k++) begin
            br.req = 4'b1111;
            push(1, "rr_hold", oh(k), 2'(k), 1'b0);
            cycle();
            r      = 4'b1111;
            r[k]   = 1'b0;
            br.req = r;
            push(1, "rr_move", oh((k + 1) % 4), 2'((k + 1) % 4), 1'b0);
            cycle();
        end

        // Mid-grant reset, pointer restarts at 0.
        br.req = 4'b1111;
        push(1, "pre_rst", oh(0), 2'd0, 1'b0);
        cycle();
        br.req = 4'b0111;
        push(1, "pre_rst", oh(1), 2'd1, 1'b0);
        cycle();
        br.req = 4'b1011;
        push(1, "pre_rst", oh(2), 2'd2, 1'b0);
        cycle();
        rst_n  = 1'b0;
        br.req = 4'b1111;
        push(1, "mid_rst", 4'b0000, 2'd0, 1'b0);
        cycle();
        rst_n = 1'b1;
        push(1, "restart", oh(0), 2'd0, 1'b0);
        cycle();
        br.req = 4'b0000;

        // Lone owner is never preempted.
        bh.req = 4'b1000;
        for (int c = 0; c < 10; c++) begin
            push(2, "hold", 4'b1000, 2'd0, 1'b0);
            cycle();
        end
        bh.req = 4'b0000;
        push(2, "hold_rel", 4'b0000, 2'd0, 1'b0);
        cycle();

        // Hold limit of 4 with a competitor arriving on cycle 2.
        bh.req = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            push(2, "pre_own", 4'b1000, 2'd0, 1'b0);
            cycle();
        end
        bh.req = 4'b1010;
        for (int c = 0; c < 2; c++) begin
            push(2, "pre_own", 4'b1000, 2'd0, 1'b0);
            cycle();
        end
        push(2, "preempt", 4'b0010, 2'd2, 1'b1);
        cycle();
        push(2, "post_pre", 4'b0010, 2'd2, 1'b0);
        cycle();
        bh.req = 4'b1000;
        push(2, "regrant", 4'b1000, 2'd0, 1'b0);
        cycle();
        bh.req = 4'b0000;
        push(2, "final", 4'b0000, 2'd0, 1'b0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
